// File: rtl/irq_ack_responder_pkg.sv
// Shared types and bus constants for the 68k-style interrupt acknowledge responder.
package mackerel_irq_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    DECODE    = 2'd2,
    RESPOND   = 2'd3
  } irq_state_e;

  localparam logic [2:0] IACK_FC      = 3'b111;
  localparam logic [3:0] IACK_ADDR_HI = 4'hF;

endpackage

// File: rtl/irq_ack_responder_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; both stages clear to zero on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_ack_responder.sv
// Interrupt pending tracker and IACK bus-cycle responder (vectored, autovector or bus error).
//
// state     | meaning
// WAIT_HIGH | after reset, wait for as_n high so a cut-off bus cycle is never answered
// IDLE      | watch for an IACK bus cycle (fc = 111, A19..A16 = F)
// DECODE    | capture acknowledged level, register the response
// RESPOND   | hold response until as_n returns high
module irq_ack_responder
  import mackerel_irq_pkg::*;
#(
  parameter logic [6:0] EDGE_MASK     = 7'b1000000,
  parameter logic [6:0] VECTORED_MASK = 7'b0000000,
  parameter logic [7:0] VECTOR_BASE   = 8'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] irq,
  input  logic       as_n,
  input  logic [2:0] fc,
  input  logic [3:0] addr_hi,
  input  logic [2:0] addr_lo,
  output logic [6:0] pending,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       dtack_n,
  output logic       vpa_n,
  output logic       berr_n,
  output logic       ack_strobe,
  output logic [2:0] ack_level
);

  logic [6:0] irq_s;
  logic       as_n_s;

  sync_2ff #(.WIDTH(7)) u_sync_irq (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (irq),
    .q_o   (irq_s)
  );

  sync_2ff #(.WIDTH(1)) u_sync_as (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (as_n),
    .q_o   (as_n_s)
  );

  irq_state_e state_q, state_d;
  logic [6:0] irq_prev_q;
  logic [6:0] edge_pend_q, edge_pend_d;
  logic [6:0] clr_mask;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       dtack_n_q, dtack_n_d;
  logic       vpa_n_q, vpa_n_d;
  logic       berr_n_q, berr_n_d;
  logic       ack_strobe_q, ack_strobe_d;
  logic [2:0] ack_level_q, ack_level_d;

  logic       iack_cyc;
  logic [7:0] pend_ext;
  logic [7:0] vec_ext;
  logic       valid_ack;

  // Bit 0 of the extended vectors stands for level 0, which is never valid.
  assign pend_ext  = {pending, 1'b0};
  assign vec_ext   = {VECTORED_MASK, 1'b0};
  assign valid_ack = pend_ext[addr_lo];
  assign iack_cyc  = !as_n_s && (fc == IACK_FC) && (addr_hi == IACK_ADDR_HI);

  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    data_oe_d    = data_oe_q;
    dtack_n_d    = dtack_n_q;
    vpa_n_d      = vpa_n_q;
    berr_n_d     = berr_n_q;
    ack_strobe_d = 1'b0;
    ack_level_d  = ack_level_q;
    clr_mask     = '0;
    case (state_q)
      WAIT_HIGH: begin
        if (as_n_s) state_d = IDLE;
      end
      IDLE: begin
        if (iack_cyc) state_d = DECODE;
      end
      DECODE: begin
        state_d = RESPOND;
        if (valid_ack) begin
          ack_strobe_d = 1'b1;
          ack_level_d  = addr_lo;
          clr_mask     = 7'b1 << (addr_lo - 3'd1);
          if (vec_ext[addr_lo]) begin
            data_out_d = VECTOR_BASE + {5'b0, addr_lo};
            data_oe_d  = 1'b1;
            dtack_n_d  = 1'b0;
          end else begin
            vpa_n_d = 1'b0;
          end
        end else begin
          berr_n_d = 1'b0;
        end
      end
      RESPOND: begin
        if (as_n_s) begin
          state_d    = IDLE;
          data_out_d = 8'h00;
          data_oe_d  = 1'b0;
          dtack_n_d  = 1'b1;
          vpa_n_d    = 1'b1;
          berr_n_d   = 1'b1;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  // A new edge in the same cycle as the acknowledge clear keeps the request pending.
  assign edge_pend_d = EDGE_MASK & ((irq_s & ~irq_prev_q) | (edge_pend_q & ~clr_mask));
  assign pending     = edge_pend_q | (irq_s & ~EDGE_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_HIGH;
      irq_prev_q   <= '0;
      edge_pend_q  <= '0;
      data_out_q   <= 8'h00;
      data_oe_q    <= 1'b0;
      dtack_n_q    <= 1'b1;
      vpa_n_q      <= 1'b1;
      berr_n_q     <= 1'b1;
      ack_strobe_q <= 1'b0;
      ack_level_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_s;
      edge_pend_q  <= edge_pend_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      dtack_n_q    <= dtack_n_d;
      vpa_n_q      <= vpa_n_d;
      berr_n_q     <= berr_n_d;
      ack_strobe_q <= ack_strobe_d;
      ack_level_q  <= ack_level_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_oe    = data_oe_q;
  assign dtack_n    = dtack_n_q;
  assign vpa_n      = vpa_n_q;
  assign berr_n     = berr_n_q;
  assign ack_strobe = ack_strobe_q;
  assign ack_level  = ack_level_q;

endmodule

// File: doc/irq_ack_responder.md
IRQ_ACK_RESPONDER -- requirements
Module: irq_ack_responder

Interface
REQ-001 SHALL have parameter EDGE_MASK, default 7'b1000000, bit n-1 = 1 makes level n edge-triggered (latched); 0 = level-sensitive.
REQ-002 SHALL have parameter VECTORED_MASK, default 7'b0000000, bit n-1 = 1 answers level n with a vector number; 0 = autovector (VPA).
REQ-003 SHALL have parameter VECTOR_BASE, default 8'h40, vector number = VECTOR_BASE + level, modulo 256.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 irq  in  7  active-high interrupt sources, bit 0 = level 1, asynchronous.
REQ-007 as_n  in  1  CPU address strobe, active-low, asynchronous.
REQ-008 fc  in  3  CPU function code.
REQ-009 addr_hi  in  4  CPU A19..A16.
REQ-010 addr_lo  in  3  CPU A3..A1, the acknowledged level.
REQ-011 pending  out  7  active-high pending requests, feeds the IPL priority encoder.
REQ-012 data_out  out  8  vector number for D7..D0.
REQ-013 data_oe  out  1  active-high enable for data_out.
REQ-014 dtack_n  out  1  active-low, vectored response.
REQ-015 vpa_n  out  1  active-low, autovector response.
REQ-016 berr_n  out  1  active-low, spurious or invalid acknowledge.
REQ-017 ack_strobe  out  1  one-cycle pulse on each valid acknowledge.
REQ-018 ack_level  out  3  level for the current ack_strobe; holds between strobes.

Function
REQ-019 SHALL pass irq and as_n each through a two-flop synchronizer; fc and addr are sampled only while synced as_n is low.
REQ-020 Edge level: a rising edge of synced irq SHALL set pending; acknowledging that level SHALL clear it; when set and clear coincide, set SHALL win.
REQ-021 Level-sensitive level: pending SHALL equal synced irq; acknowledge SHALL NOT alter it.
REQ-022 FSM states SHALL be WAIT_HIGH, IDLE, DECODE and RESPOND.
REQ-023 WAIT_HIGH SHALL move to IDLE when synced as_n is high.
REQ-024 IDLE SHALL move to DECODE when synced as_n is low, fc = 3'b111 and addr_hi = 4'hF; any other cycle SHALL leave it in IDLE with outputs inactive.
REQ-025 DECODE SHALL capture L = addr_lo, move to RESPOND, and register the response so it drives outputs on the first RESPOND cycle.
REQ-026 Valid acknowledge (L != 0 and pending[L] = 1) with VECTORED_MASK[L] set: data_out = VECTOR_BASE+L, data_oe = 1, dtack_n = 0.
REQ-027 Valid acknowledge with VECTORED_MASK[L] clear: vpa_n = 0.
REQ-028 L = 0 or pending[L] = 0: berr_n = 0 only; no pending change and no ack_strobe.
REQ-029 ack_strobe SHALL pulse and ack_level = L SHALL load on the DECODE-to-RESPOND transition for valid acknowledges only.
REQ-030 RESPOND SHALL hold its outputs until synced as_n is high, then deassert all responses on the same edge as the move to IDLE.
REQ-031 Latency: with synced as_n first low in cycle n, the response SHALL be asserted at cycle n+2.
REQ-032 irq changes during RESPOND SHALL update pending but SHALL NOT alter the response in progress.

Reset
REQ-033 rst_n low SHALL immediately force: state WAIT_HIGH; pending 0; synchronizers 0, so no edge is latched from pre-reset history; data_out 8'h00; data_oe 0; dtack_n, vpa_n and berr_n 1; ack_strobe 0; ack_level 0.
REQ-034 Reset during a bus cycle SHALL NOT produce a response until as_n has been seen high.

Structure
REQ-035 Package mackerel_irq_pkg SHALL hold the FSM state enum, IACK_FC = 3'b111 and IACK_ADDR_HI = 4'hF.
REQ-036 A single sub-module sync_2ff, parameterized by width, SHALL implement the synchronizers.

Verification
REQ-037 EDGE_MASK default: pulse irq[6] -> pending[6] = 1; IACK with addr_lo = 7 -> vpa_n = 0, ack_strobe pulses once, pending[6] = 0 after.
REQ-038 VECTORED_MASK = 7'b0000100, irq[2] held high: IACK with addr_lo = 3 -> data_out = 8'h43, data_oe = 1, dtack_n = 0; pending[2] stays 1.
REQ-039 No irq asserted: IACK with addr_lo = 5 -> berr_n = 0; no ack_strobe; pending = 0.
REQ-040 fc = 3'b101 with addr_hi = 4'hF and as_n low -> all responses inactive for the whole cycle.
REQ-041 Assert rst_n low during RESPOND with as_n still low, then release -> outputs inactive at once and no response until as_n goes high and a new IACK arrives.
REQ-042 Level-7 edge coinciding with the level-7 acknowledge clear -> pending[6] = 1 after the acknowledge.
